// File: rtl/hack_serial_pkg.sv
// hack_serial_pkg: shared state encoding and default word width for the Hack serial blocks
package hack_serial_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/bit_counter.sv
// bit_counter: up-counter over 0..WIDTH-1 with synchronous clear, enable and terminal count
//   clk, reset_n : clock, asynchronous active-low reset
//   clr, en      : clear to 0 (wins over en), count up by one
//   cnt, tc      : current count, high when cnt == WIDTH-1
module bit_counter
  import hack_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     tc
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign tc  = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/word_serializer.sv
// word_serializer: parallel word in over valid/ready, one bit out per accepted serial beat
//   clk, reset_n                   : clock, asynchronous active-low reset
//   in_data, in_valid, in_ready    : parallel word handshake (ready only when idle)
//   ser_data, ser_valid, ser_last  : serial bit, valid while a word is in flight, final-bit flag
//   ser_ready                      : sink accepts the current bit
//   busy, done                     : word in flight, one-cycle pulse after the final bit is taken
module word_serializer
  import hack_serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic             load, accept, tc;
  logic [CW-1:0]    bit_cnt;
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == SHIFT;
  assign ser_valid = busy;
  assign ser_last  = busy && bit_cnt == CW'(WIDTH - 1);
  assign ser_data  = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
  assign done      = done_q;
  assign load      = in_valid && in_ready;
  assign accept    = ser_valid && ser_ready;
  always_comb begin
    done_d  = accept && tc;
    shift_d = load ? in_data
            : accept ? (LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], 1'b0})
            : shift_q;
    state_d = load ? SHIFT : done_d ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  // Clearing on the final beat keeps the count inside 0..WIDTH-1 for any WIDTH.
  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (load || done_d),
    .en     (accept),
    .cnt    (bit_cnt),
    .tc     (tc)
  );
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench for word_serializer, MSB-first and LSB-first instances
module tb_word_serializer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_valid = '0;
  logic        ser_ready = 1'b1;
  logic [1:0]  in_ready, ser_data, ser_valid, ser_last, busy, done;
  int          checks = 0;
  int          errors = 0;
  int          rmode = 0;
  int          ph = 0;
  int          dones[2] = '{0, 0};
  logic [1:0]  q0[$];
  logic [1:0]  q1[$];
  logic [1:0]  prev[2];
  bit          stalled[2] = '{0, 0};

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_data(ser_data[0]), .ser_valid(ser_valid[0]),
    .ser_last(ser_last[0]), .ser_ready(ser_ready), .busy(busy[0]), .done(done[0])
  );

  word_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_data(ser_data[1]), .ser_valid(ser_valid[1]),
    .ser_last(ser_last[1]), .ser_ready(ser_ready), .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input int k, input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] e;
      e = {i == 15, (k == 1) ? w[i] : w[15-i]};
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic beat(input int k);
    logic [1:0] e;
    if (!reset_n) begin
      stalled[k] = 1'b0;
      return;
    end
    if (stalled[k]) check($sformatf("hold%0d", k), {ser_last[k], ser_data[k]}, prev[k]);
    if (done[k]) begin
      dones[k]++;
      check($sformatf("done_excl_valid%0d", k), ser_valid[k], 0);
    end
    if (ser_valid[k] && ser_ready) begin
      if ((k == 0 ? q0.size() : q1.size()) == 0) check($sformatf("extra_beat%0d", k), 1, 0);
      else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("bit%0d", k), {ser_last[k], ser_data[k]}, e);
      end
    end
    stalled[k] = ser_valid[k] && !ser_ready;
    prev[k] = {ser_last[k], ser_data[k]};
  endtask

  always @(negedge clk) begin
    beat(0);
    beat(1);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ph++;
      ser_ready = (rmode == 0) ? 1'b1 : (ph % 4 == 0 || ph % 4 == 3);
    end
  end

  task automatic send(input int k, input logic [15:0] w);
    int n;
    n = 0;
    in_data = w;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("accept_timeout", n < 200, 1);
    expect_word(k, w);
    @(posedge clk);
    #2;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!done[k] && n < 200);
    check("done_timeout", done[k], 1);
  endtask

  initial begin
    int n, d0, idle, dn;
    #1 reset_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready[0], 1);
    check("rst_in_ready_lsb", in_ready[1], 1);
    check("rst_ser_valid", ser_valid[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_ser_last", ser_last[0], 0);
    check("rst_ser_data", ser_data[0], 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;

    d0 = dones[0];
    send(0, 16'hA5C3);
    check("a_in_ready_low", in_ready[0], 0);
    check("a_busy", busy[0], 1);
    check("a_first_bit", ser_data[0], 1);
    wait_done(0, n);
    check("a_latency", n, 17);
    check("a_in_ready_back", in_ready[0], 1);
    @(negedge clk);
    #1;
    check("a_done_one_cycle", done[0], 0);
    check("a_done_count", dones[0] - d0, 1);
    check("a_queue_empty", q0.size(), 0);

    rmode = 1;
    d0 = dones[0];
    send(0, 16'hA5C3);
    wait_done(0, n);
    @(negedge clk);
    #1;
    check("b_done_one_cycle", done[0], 0);
    check("b_done_count", dones[0] - d0, 1);
    check("b_queue_empty", q0.size(), 0);
    rmode = 0;
    repeat (2) @(posedge clk);
    #2;

    send(1, 16'h0001);
    check("l_first_bit", ser_data[1], 1);
    wait_done(1, n);
    check("l_latency", n, 17);
    check("l_queue_empty", q1.size(), 0);

    d0 = dones[0];
    send(0, 16'h0000);
    send(0, 16'hFFFF);
    wait_done(0, n);
    check("i_latency", n, 17);
    @(negedge clk);
    #1;
    check("i_done_count", dones[0] - d0, 2);
    check("i_queue_empty", q0.size(), 0);

    send(0, 16'hF0F0);
    repeat (5) begin
      @(posedge clk);
      #2;
    end
    reset_n = 1'b0;
    #1;
    check("r_ser_valid", ser_valid[0], 0);
    check("r_busy", busy[0], 0);
    check("r_in_ready", in_ready[0], 1);
    check("r_ser_last", ser_last[0], 0);
    q0.delete();
    d0 = dones[0];
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    check("r_no_done", dones[0] - d0, 0);
    check("r_idle", busy[0], 0);
    send(0, 16'h8001);
    check("r_first_bit", ser_data[0], 1);
    wait_done(0, n);
    check("r_latency", n, 17);
    check("r_queue_empty", q0.size(), 0);
    @(negedge clk);
    #1;

    in_data = 16'h1234;
    in_valid[0] = 1'b1;
    expect_word(0, 16'h1234);
    @(posedge clk);
    #2;
    in_data = 16'hBEEF;
    expect_word(0, 16'hBEEF);
    n = 0;
    idle = 0;
    dn = 0;
    while (dn < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
      if (!ser_valid[0]) idle++;
      if (done[0]) dn++;
      if (n == 18) in_valid[0] = 1'b0;
    end
    in_valid[0] = 1'b0;
    check("bb_cycles", n, 34);
    check("bb_dones", dn, 2);
    check("bb_idle", idle, 2);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    check("bb_queue_empty", q0.size(), 0);
    check("bb_idle_after", busy[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
